// File: rtl/botao_condicionador.sv
// Pedestrian-button conditioner placed in front of the semaforo controller.
// Path: raw level -> two-flop synchronizer -> debounce -> one-cycle request
// pulse with a minimum spacing between requests and at most one pending press.
module botao_condicionador #(
  parameter logic [7:0] DEBOUNCE_CYCLES = 8'd4,
  parameter logic [7:0] LOCKOUT_CYCLES  = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_raw,
  output logic       bt,
  output logic       pressed,
  output logic       locked,
  output logic       lost,
  output logic [1:0] state_dbg
);

  // Request protocol towards semaforo: bt is a fire-and-forget pulse with no
  // ready/back-pressure. It is high for exactly one cycle per accepted press,
  // and two rising edges are never closer than LOCKOUT_CYCLES cycles.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK      = 2'd1,
    LOCK_PEND = 2'd2
  } state_t;

  state_t     state;
  logic       s1;
  logic       s;
  logic       stable;
  logic [7:0] cnt;
  logic [7:0] lc;
  logic       rise;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= bt_raw;
      s  <= s1;
    end
  end

  // Debounce: accept a new level only after it has differed from the
  // accepted one for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // in between restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= 8'd0;
    end else if (s == stable) begin
      cnt <= 8'd0;
    end else if (cnt == DEBOUNCE_CYCLES - 8'd1) begin
      stable <= s;
      cnt    <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // A press event is the edge on which the accepted level goes 0 -> 1;
  // releases produce no event.
  assign rise = !stable && s && (cnt == DEBOUNCE_CYCLES - 8'd1);

  // Lockout FSM: issues bt, times the spacing, and remembers one press that
  // arrives during lockout. Further presses while one is pending are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lc    <= 8'd0;
      bt    <= 1'b0;
      lost  <= 1'b0;
    end else begin
      bt   <= 1'b0;
      lost <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            bt    <= 1'b1;
            lc    <= LOCKOUT_CYCLES - 8'd1;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (lc != 8'd0) begin
            lc <= lc - 8'd1;
            if (rise) state <= LOCK_PEND;
          end else if (rise) begin
            // Expiry coincides with a fresh press: serve it immediately.
            bt <= 1'b1;
            lc <= LOCKOUT_CYCLES - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        LOCK_PEND: begin
          if (lc != 8'd0) begin
            lc <= lc - 8'd1;
            if (rise) lost <= 1'b1;
          end else begin
            // Serve the pending press; a coincident press becomes the new
            // pending one.
            bt    <= 1'b1;
            lc    <= LOCKOUT_CYCLES - 8'd1;
            state <= rise ? LOCK_PEND : LOCK;
          end
        end
        default: begin
          state <= IDLE;
          lc    <= 8'd0;
        end
      endcase
    end
  end

  assign pressed   = stable;
  assign locked    = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_botao_condicionador.sv
// Self-checking bench for botao_condicionador.
// u_dut uses the default debounce/lockout (4/8) for press, glitch and bounce
// scenarios. With a debounce of 4 a second press cannot be accepted within
// 8 cycles, so u_pend (debounce 1, lockout 8) covers the pending, dropped
// press and reset-while-pending scenarios.
module tb_botao_condicionador;

  logic       clk;
  logic       rst;
  logic       raw_a;
  logic       raw_b;
  logic       bt_a, pressed_a, locked_a, lost_a;
  logic       bt_b, pressed_b, locked_b, lost_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_bt_a_q[$];
  logic [31:0] exp_lost_a_q[$];
  logic [31:0] exp_bt_b_q[$];
  logic [31:0] exp_lost_b_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  botao_condicionador #(.DEBOUNCE_CYCLES(8'd4), .LOCKOUT_CYCLES(8'd8)) u_dut (
    .clk(clk), .rst(rst), .bt_raw(raw_a), .bt(bt_a), .pressed(pressed_a),
    .locked(locked_a), .lost(lost_a), .state_dbg(state_a)
  );

  botao_condicionador #(.DEBOUNCE_CYCLES(8'd1), .LOCKOUT_CYCLES(8'd8)) u_pend (
    .clk(clk), .rst(rst), .bt_raw(raw_b), .bt(bt_b), .pressed(pressed_b),
    .locked(locked_b), .lost(lost_b), .state_dbg(state_b)
  );

  // Clock and edge counter: after posedge k, cyc == k.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard: every bt / lost pulse must match the next expected edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bt_a) begin
        if (exp_bt_a_q.size() == 0) check("bt_a_extra", 1, 0);
        else check("bt_a_time", cyc, exp_bt_a_q.pop_front());
      end
      if (lost_a) begin
        if (exp_lost_a_q.size() == 0) check("lost_a_extra", 1, 0);
        else check("lost_a_time", cyc, exp_lost_a_q.pop_front());
      end
      if (bt_b) begin
        if (exp_bt_b_q.size() == 0) check("bt_b_extra", 1, 0);
        else check("bt_b_time", cyc, exp_bt_b_q.pop_front());
      end
      if (lost_b) begin
        if (exp_lost_b_q.size() == 0) check("lost_b_extra", 1, 0);
        else check("lost_b_time", cyc, exp_lost_b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drives raw_b so that u_pend accepts presses at p, p+3 and p+5 (p = c+3).
  task automatic triple_press_b(input int c);
    raw_b = 1'b1;
    wait_until(c + 1); raw_b = 1'b0;
    wait_until(c + 3); raw_b = 1'b1;
    wait_until(c + 4); raw_b = 1'b0;
    wait_until(c + 5); raw_b = 1'b1;
  endtask

  initial begin
    int c;
    int p;
    rst   = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bt", bt_a, 0);
    check("rst_pressed", pressed_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_lost", lost_a, 0);
    check("rst_state", state_a, ST_IDLE);
    check("rst_locked_b", locked_b, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press: raw high at edges c+1..c+12, accepted at c+6.
    c = cyc;
    raw_a = 1'b1;
    exp_bt_a_q.push_back(c + 6);
    wait_until(c + 5);  check("s1_pressed_pre", pressed_a, 0);
    check("s1_locked_pre", locked_a, 0);
    wait_until(c + 6);  check("s1_pressed", pressed_a, 1);
    check("s1_locked", locked_a, 1);
    wait_until(c + 12); raw_a = 1'b0;
    wait_until(c + 13); check("s1_locked_hold", locked_a, 1);
    wait_until(c + 14); check("s1_locked_end", locked_a, 0);
    wait_until(c + 17); check("s1_pressed_hold", pressed_a, 1);
    wait_until(c + 18); check("s1_pressed_fall", pressed_a, 0);
    wait_until(c + 30);

    // Glitch: raw high for three edges only.
    c = cyc;
    raw_a = 1'b1;
    wait_until(c + 3);  raw_a = 1'b0;
    wait_until(c + 5);  check("s2_cnt_peak", u_dut.cnt, 3);
    wait_until(c + 6);  check("s2_cnt_clear", u_dut.cnt, 0);
    check("s2_pressed", pressed_a, 0);
    wait_until(c + 20); check("s2_locked", locked_a, 0);
    check("s2_pressed_end", pressed_a, 0);

    // Bounce while held: two-cycle dropout must not re-trigger.
    c = cyc;
    raw_a = 1'b1;
    exp_bt_a_q.push_back(c + 6);
    wait_until(c + 6);  check("s3_pressed", pressed_a, 1);
    wait_until(c + 10); raw_a = 1'b0;
    wait_until(c + 12); raw_a = 1'b1;
    wait_until(c + 14); check("s3_pressed_bounce", pressed_a, 1);
    wait_until(c + 20); check("s3_pressed_after", pressed_a, 1);
    wait_until(c + 25); raw_a = 1'b0;
    wait_until(c + 45); check("s3_pressed_end", pressed_a, 0);
    check("s3_locked_end", locked_a, 0);

    // Press during lockout: second press at p+3 is served at p+8.
    c = cyc;
    p = c + 3;
    exp_bt_b_q.push_back(p);
    exp_bt_b_q.push_back(p + 8);
    raw_b = 1'b1;
    wait_until(c + 1);  raw_b = 1'b0;
    wait_until(c + 3);  raw_b = 1'b1;
    check("s4_state_lock", state_b, ST_LOCK);
    wait_until(p + 3);  check("s4_state_pend", state_b, ST_PEND);
    wait_until(p + 8);  check("s4_state_relock", state_b, ST_LOCK);
    wait_until(p + 15); check("s4_locked_hold", locked_b, 1);
    wait_until(p + 16); check("s4_locked_end", locked_b, 0);
    raw_b = 1'b0;
    wait_until(p + 25);

    // Third press while one is pending is dropped.
    c = cyc;
    p = c + 3;
    exp_bt_b_q.push_back(p);
    exp_bt_b_q.push_back(p + 8);
    exp_lost_b_q.push_back(p + 5);
    triple_press_b(c);
    wait_until(p + 5);  check("s5_lost", lost_b, 1);
    check("s5_state_pend", state_b, ST_PEND);
    wait_until(p + 6);  check("s5_lost_clear", lost_b, 0);
    wait_until(p + 16); check("s5_locked_end", locked_b, 0);
    raw_b = 1'b0;
    wait_until(p + 25);

    // Asynchronous reset while a press is pending.
    c = cyc;
    p = c + 3;
    exp_bt_b_q.push_back(p);
    exp_lost_b_q.push_back(p + 5);
    triple_press_b(c);
    wait_until(p + 5);  check("s6_pressed_pre", pressed_b, 1);
    check("s6_state_pre", state_b, ST_PEND);
    #2;
    rst = 1'b1;
    #1;
    check("s6_bt_async", bt_b, 0);
    check("s6_locked_async", locked_b, 0);
    check("s6_lost_async", lost_b, 0);
    check("s6_pressed_async", pressed_b, 0);
    check("s6_state_async", state_b, ST_IDLE);
    raw_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    wait_until(c + 20);
    check("s6_locked_after", locked_b, 0);
    check("s6_pressed_after", pressed_b, 0);

    check("q_bt_a_left", exp_bt_a_q.size(), 0);
    check("q_lost_a_left", exp_lost_a_q.size(), 0);
    check("q_bt_b_left", exp_bt_b_q.size(), 0);
    check("q_lost_b_left", exp_lost_b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
